mips_multicycle_ctrl: RTL

Main control FSM for the multicycle variant of the MIPS-1 core. Each instruction is split into 3–5 steps over one shared memory, one ALU and the regfile. The block sequences those steps and drives every datapath select and write enable. It decodes opcode and funct, generates the 3-bit ALU control, and stalls on memory through a ready handshake.

---
 rtl/mips_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM for the multicycle MIPS-1 core
//
// Sequences the 3-5 steps of each instruction over the shared memory, ALU and
// regfile, and drives every datapath select and write enable.
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   op_i, funct_i       instruction[31:26] and instruction[5:0] from the IR
//   mem_ready_i         memory completes the current access this cycle
//   mem_req_o, iord_o, mem_write_o         memory request / address select / write
//   ir_write_o, pc_write_o, branch_o       IR load, PC load, conditional PC load
//   pc_src_o, alu_src_a_o, alu_src_b_o     PC and ALU operand selects
//   alu_control_o                          3-bit ALU operation
//   reg_dst_o, mem_to_reg_o, reg_write_o   regfile address/data select, write enable
//   state_o, illegal_o                     debug state, unsupported instruction flag
module mips_multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       iord_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       branch_o,
    output logic [1:0] pc_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_control_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    logic       funct_ok;
    logic [2:0] funct_alu;

    // Funct decode shared by the DECODE legality check and RTYPEEX.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct_i)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready_i ? DECODE : FETCH;
            DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? RTYPEEX : FETCH;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op_i == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = mem_ready_i ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready_i ? FETCH : MEMWR;
            RTYPEEX: state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BEQEX:   state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JEX:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        mem_req_o     = 1'b0;
        iord_o        = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        branch_o      = 1'b0;
        pc_src_o      = 2'b00;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        alu_control_o = ALU_ADD;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_write_o   = 1'b0;
        illegal_o     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;
                // Reset masks the PC/IR loads so a fetch completing while
                // rst_i is high cannot commit anything.
                ir_write_o  = mem_ready_i & ~rst_i;
                pc_write_o  = mem_ready_i & ~rst_i;
            end
            DECODE: begin
                alu_src_b_o = 2'b11;
                case (op_i)
                    OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_o = 1'b0;
                    OP_RTYPE: illegal_o = ~funct_ok;
                    default:  illegal_o = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            MEMRD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            MEMWR: begin
                mem_req_o   = 1'b1;
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a_o   = 1'b1;
                alu_control_o = funct_alu;
            end
            RTYPEWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            BEQEX: begin
                alu_src_a_o   = 1'b1;
                alu_control_o = ALU_SUB;
                branch_o      = 1'b1;
                pc_src_o      = 2'b01;
            end
            ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            ADDIWB: begin
                reg_write_o = 1'b1;
            end
            JEX: begin
                pc_write_o = ~rst_i;
                pc_src_o   = 2'b10;
            end
            default: begin
            end
        endcase
    end

    assign state_o = state_q;

endmodule
